// File: rtl/vmem_addr_gen_if.sv
// Request, store-data, buffer-write and completion signals of the
// vector memory address generator.
interface vmem_addr_gen_if #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MICROOP_WIDTH = 7,
  parameter int TICKET_WIDTH  = 5,
  parameter int SIZE_WIDTH    = 3,
  parameter int VL_WIDTH      = 8
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [ADDR_BITS-1:0]     req_base_i;
  logic [ADDR_BITS-1:0]     req_stride_i;
  logic                     req_strided_i;
  logic [VL_WIDTH-1:0]      req_vl_i;
  logic [MICROOP_WIDTH-1:0] req_microop_i;
  logic [TICKET_WIDTH-1:0]  req_ticket_i;
  logic [SIZE_WIDTH-1:0]    req_size_i;
  logic                     st_data_valid_i;
  logic [DATA_WIDTH-1:0]    st_data_i;
  logic                     st_data_ready_o;
  logic                     buf_ready_i;
  logic                     push_o;
  logic [ADDR_BITS-1:0]     write_address_o;
  logic [DATA_WIDTH-1:0]    write_data_o;
  logic [TICKET_WIDTH-1:0]  write_ticket_o;
  logic [MICROOP_WIDTH-1:0] write_microop_o;
  logic [SIZE_WIDTH-1:0]    write_size_o;
  logic                     done_o;
  logic [TICKET_WIDTH-1:0]  done_ticket_o;

  modport slave (
    input  req_valid_i, req_base_i, req_stride_i,
    input  req_strided_i, req_vl_i, req_microop_i,
    input  req_ticket_i, req_size_i,
    input  st_data_valid_i, st_data_i, buf_ready_i,
    output req_ready_o, st_data_ready_o, push_o,
    output write_address_o, write_data_o,
    output write_ticket_o, write_microop_o,
    output write_size_o, done_o, done_ticket_o
  );

  modport master (
    output req_valid_i, req_base_i, req_stride_i,
    output req_strided_i, req_vl_i, req_microop_i,
    output req_ticket_i, req_size_i,
    output st_data_valid_i, st_data_i, buf_ready_i,
    input  req_ready_o, st_data_ready_o, push_o,
    input  write_address_o, write_data_o,
    input  write_ticket_o, write_microop_o,
    input  write_size_o, done_o, done_ticket_o
  );
endinterface

// File: rtl/vmem_addr_gen.sv
// Vector memory address generator: expands one unit/strided request
// into per-element writes to the load/store buffer.
module vmem_addr_gen #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MICROOP_WIDTH = 7,
  parameter int TICKET_WIDTH  = 5,
  parameter int SIZE_WIDTH    = 3,
  parameter int VL_WIDTH      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  vmem_addr_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic [ADDR_BITS-1:0]     stride_q, stride_d;
  logic [VL_WIDTH-1:0]      idx_q, idx_d;
  logic [VL_WIDTH-1:0]      vl_q, vl_d;
  logic [MICROOP_WIDTH-1:0] uop_q, uop_d;
  logic [TICKET_WIDTH-1:0]  tkt_q, tkt_d;
  logic [SIZE_WIDTH-1:0]    size_q, size_d;
  logic                     accept, store, push;

  assign store = (uop_q[4:3] == 2'b11);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    vl_d     = vl_q;
    uop_d    = uop_q;
    tkt_d    = tkt_q;
    size_d   = size_q;
    accept   = (state_q == IDLE) & bus.req_valid_i & ~flush_i;
    push     = (state_q == ISSUE) & bus.buf_ready_i & ~flush_i
             & (~store | bus.st_data_valid_i);
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = bus.req_base_i;
          idx_d    = '0;
          vl_d     = bus.req_vl_i;
          uop_d    = bus.req_microop_i;
          tkt_d    = bus.req_ticket_i;
          size_d   = bus.req_size_i;
          // effective stride resolved once at accept time
          stride_d = bus.req_strided_i ? bus.req_stride_i
                   : (ADDR_BITS'(1) << bus.req_size_i);
          state_d  = (bus.req_vl_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (push) begin
          addr_d = addr_q + stride_q;
          idx_d  = idx_q + VL_WIDTH'(1);
          if (idx_q == vl_q - VL_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      vl_q     <= '0;
      uop_q    <= '0;
      tkt_q    <= '0;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
      vl_q     <= vl_d;
      uop_q    <= uop_d;
      tkt_q    <= tkt_d;
      size_q   <= size_d;
    end
  end

  assign bus.req_ready_o     = (state_q == IDLE) & ~flush_i;
  assign bus.push_o          = push;
  assign bus.st_data_ready_o = push & store;
  assign bus.write_address_o = addr_q;
  assign bus.write_data_o    = store ? bus.st_data_i : '0;
  assign bus.write_ticket_o  = tkt_q;
  assign bus.write_microop_o = uop_q;
  assign bus.write_size_o    = size_q;
  assign bus.done_o          = (state_q == DONE) & ~flush_i;
  assign bus.done_ticket_o   = tkt_q;
endmodule

// File: doc/vmem_addr_gen.md
VMEM_ADDR_GEN -- requirements
Module: vmem_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, element data width.
REQ-003 SHALL have parameter MICROOP_WIDTH, default 7, micro-op width.
REQ-004 SHALL have parameter TICKET_WIDTH, default 5, ROB ticket width.
REQ-005 SHALL have parameter SIZE_WIDTH, default 3, element size code width.
REQ-006 SHALL have parameter VL_WIDTH, default 8, vector length width.
REQ-007 SHALL have port clk, input, 1, single clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port flush_i, input, 1, abort current operation.
REQ-010 SHALL have port req_valid_i, input, 1, vector memory request valid.
REQ-011 SHALL have port req_ready_o, output, 1, request accepted when high with req_valid_i.
REQ-012 SHALL have port req_base_i, input, ADDR_BITS, base address.
REQ-013 SHALL have port req_stride_i, input, ADDR_BITS, byte stride, two's complement.
REQ-014 SHALL have port req_strided_i, input, 1: 1 = use req_stride_i; 0 = unit stride.
REQ-015 SHALL have port req_vl_i, input, VL_WIDTH, element count.
REQ-016 SHALL have ports req_microop_i, req_ticket_i and req_size_i, inputs, each of its parameter width; req_size_i is log2 of element bytes.
REQ-017 SHALL have port st_data_valid_i, input, 1, store element data valid.
REQ-018 SHALL have port st_data_i, input, DATA_WIDTH, store element data.
REQ-019 SHALL have port st_data_ready_o, output, 1, store element consumed.
REQ-020 SHALL have port buf_ready_i, input, 1, downstream load/store buffer not full.
REQ-021 SHALL have port push_o, input-side, output, 1, element write into the buffer.
REQ-022 SHALL have ports write_address_o, write_data_o, write_ticket_o, write_microop_o and write_size_o, outputs, buffer write fields.
REQ-023 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-024 SHALL have port done_ticket_o, output, TICKET_WIDTH, ticket of the completed operation.

Function
REQ-025 SHALL implement FSM states IDLE, ISSUE and DONE.
REQ-026 SHALL drive req_ready_o=1 only in IDLE; on accept, SHALL latch all req_* fields and SHALL set addr=req_base_i and idx=0.
REQ-027 SHALL transition on accept to DONE when req_vl_i==0 (no pushes), else to ISSUE.
REQ-028 SHALL treat an operation as a store iff microop[4:3]==2'b11.
REQ-029 SHALL set the effective stride to req_stride_i when strided, else 1<<req_size_i.
REQ-030 SHALL, in ISSUE, assert push_o = buf_ready_i & !flush_i & (!store | st_data_valid_i), combinationally.
REQ-031 SHALL assert st_data_ready_o = push_o & store; for loads, st_data_ready_o SHALL be 0 and write_data_o SHALL be 0.
REQ-032 SHALL drive write_address_o=addr, write_data_o=st_data_i (stores), and the latched ticket, microop and size.
REQ-033 SHALL, on push, update addr <= addr + stride modulo 2^ADDR_BITS, update idx <= idx+1, and go to DONE when idx==vl-1.
REQ-034 SHALL hold all outputs stable while stalled, with no push while buf_ready_i=0 or store data is absent.
REQ-035 SHALL assert done_o=1 with done_ticket_o=latched ticket for exactly one cycle in DONE, then return to IDLE.
REQ-036 SHALL sustain a throughput of 1 element per cycle when unstalled; VL elements plus the DONE cycle take VL+1 cycles after accept.
REQ-037 SHALL, on flush_i in any state, go to IDLE next cycle, with no push and no done_o in that cycle and req_ready_o=0 during the flush cycle.
REQ-038 SHALL keep done_o and push_o low in IDLE.

Reset
REQ-039 SHALL, on rst_n low, force state IDLE and set addr, idx, latched fields, done_o and push_o to 0 asynchronously; req_ready_o SHALL be 1 after release.
REQ-040 SHALL treat reset mid-ISSUE as an abort, with no further pushes and no done_o.

Verification
REQ-041 Load with base 0x1000, unit stride, size 2, vl 4, buf_ready_i=1 -> pushes 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles, then done_o for 1 cycle.
REQ-042 Strided load with base 0x2000, stride -8, vl 3 -> addresses 0x2000, 0x1FF8, 0x1FF0.
REQ-043 Store with vl 2 where st_data_valid_i is low for 2 cycles -> no push while low; then push with data and st_data_ready_o=1, done after 2nd element.
REQ-044 buf_ready_i deasserted mid-op -> push_o=0 with outputs held; resume at the same address and no element is lost.
REQ-045 vl=0 -> zero pushes; done_o one cycle after accept.
REQ-046 flush_i at element 2 of 5 -> IDLE next cycle, no done_o; base 0xFFFFFFFC, stride 4 -> wraps to 0x0.
